// File: rtl/bcd_conv_arbiter.sv
// Round-robin arbiter that shares one sequential binary-to-BCD converter among
// NUM_REQ requesters and returns each result, or a timeout abort, to the granted requester.
module bcd_conv_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 13,
    parameter int BCD_W   = 16,
    parameter int TIMEOUT = 63
) (
    input  logic                      sys_clk,
    input  logic                      sys_rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [BCD_W-1:0]          rsp_bcd,
    output logic                      rsp_err,
    output logic                      conv_start,
    output logic [DATA_W-1:0]         conv_bin,
    input  logic                      conv_done,
    input  logic [BCD_W-1:0]          conv_bcd,
    output logic                      busy
);

    localparam int                 IDX_W        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [IDX_W:0]     NUM_REQ_C    = (IDX_W+1)'(NUM_REQ);
    localparam logic [IDX_W-1:0]   LAST_IDX     = IDX_W'(NUM_REQ - 1);
    localparam logic [7:0]         TIMEOUT_LAST = 8'(TIMEOUT - 1);
    localparam logic [NUM_REQ-1:0] ONE_HOT_LSB  = {{(NUM_REQ-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t              state_r;
    logic [IDX_W-1:0]    rr_ptr_r;
    logic [IDX_W-1:0]    grant_idx_r;
    logic [7:0]          timeout_cnt_r;
    logic [NUM_REQ-1:0]  rsp_valid_r;
    logic [BCD_W-1:0]    rsp_bcd_r;
    logic                rsp_err_r;
    logic                conv_start_r;
    logic [DATA_W-1:0]   conv_bin_r;
    logic                busy_r;

    logic                win_found_s;
    logic [IDX_W-1:0]    win_idx_s;
    logic [IDX_W:0]      cand_s;
    logic [IDX_W:0]      cand_wrap_s;
    logic [DATA_W-1:0]   win_data_s;
    logic [NUM_REQ-1:0]  req_ready_s;
    logic                accept_s;
    logic                timeout_hit_s;

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
        return (idx == LAST_IDX) ? {IDX_W{1'b0}} : idx + IDX_W'(1);
    endfunction

    // Round-robin search starting at rr_ptr_r, wrapping modulo NUM_REQ.
    always_comb begin
        win_found_s = 1'b0;
        win_idx_s   = '0;
        cand_s      = '0;
        cand_wrap_s = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            cand_s      = {1'b0, rr_ptr_r} + (IDX_W+1)'(off);
            cand_wrap_s = (cand_s >= NUM_REQ_C) ? (cand_s - NUM_REQ_C) : cand_s;
            if (!win_found_s && req_valid[cand_wrap_s[IDX_W-1:0]]) begin
                win_found_s = 1'b1;
                win_idx_s   = cand_wrap_s[IDX_W-1:0];
            end else begin
                win_idx_s   = win_idx_s;
            end
        end
    end

    assign win_data_s    = req_data[int'(win_idx_s)*DATA_W +: DATA_W];
    assign accept_s      = (state_r == ST_IDLE) && win_found_s;
    assign timeout_hit_s = (timeout_cnt_r == TIMEOUT_LAST);

    // Accept strobe follows req_valid in IDLE; forced low while reset is held.
    always_comb begin
        req_ready_s = '0;
        if (accept_s && sys_rst_n) begin
            req_ready_s[win_idx_s] = 1'b1;
        end else begin
            req_ready_s = '0;
        end
    end

    // Control FSM with all response and converter-side outputs registered.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_r       <= ST_IDLE;
            rr_ptr_r      <= '0;
            grant_idx_r   <= '0;
            timeout_cnt_r <= 8'd0;
            rsp_valid_r   <= '0;
            rsp_bcd_r     <= '0;
            rsp_err_r     <= 1'b0;
            conv_start_r  <= 1'b0;
            conv_bin_r    <= '0;
            busy_r        <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    rsp_valid_r <= '0;
                    if (accept_s) begin
                        grant_idx_r  <= win_idx_s;
                        conv_bin_r   <= win_data_s;
                        rr_ptr_r     <= next_idx(win_idx_s);
                        conv_start_r <= 1'b1;
                        busy_r       <= 1'b1;
                        state_r      <= ST_START;
                    end
                end
                ST_START: begin
                    conv_start_r  <= 1'b0;
                    timeout_cnt_r <= 8'd0;
                    state_r       <= ST_WAIT;
                end
                ST_WAIT: begin
                    timeout_cnt_r <= timeout_cnt_r + 8'd1;
                    // A completion in the timeout cycle still counts as success.
                    if (conv_done) begin
                        rsp_bcd_r   <= conv_bcd;
                        rsp_err_r   <= 1'b0;
                        rsp_valid_r <= ONE_HOT_LSB << grant_idx_r;
                        state_r     <= ST_RESP;
                    end else if (timeout_hit_s) begin
                        rsp_bcd_r   <= '0;
                        rsp_err_r   <= 1'b1;
                        rsp_valid_r <= ONE_HOT_LSB << grant_idx_r;
                        state_r     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    rsp_valid_r <= '0;
                    busy_r      <= 1'b0;
                    state_r     <= ST_IDLE;
                end
                default: begin
                    rsp_valid_r  <= '0;
                    conv_start_r <= 1'b0;
                    busy_r       <= 1'b0;
                    state_r      <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready  = req_ready_s;
    assign rsp_valid  = rsp_valid_r;
    assign rsp_bcd    = rsp_bcd_r;
    assign rsp_err    = rsp_err_r;
    assign conv_start = conv_start_r;
    assign conv_bin   = conv_bin_r;
    assign busy       = busy_r;

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// Directed self-checking bench for bcd_conv_arbiter with a behavioural
// fixed-latency converter model and a manual late-done injector.
module tb_bcd_conv_arbiter;

    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 13;
    localparam int BCD_W   = 16;

    logic                      sys_clk = 1'b0;
    logic                      sys_rst_n = 1'b0;
    logic [NUM_REQ-1:0]        req_valid = '0;
    logic [NUM_REQ*DATA_W-1:0] req_data = '0;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [BCD_W-1:0]          rsp_bcd;
    logic                      rsp_err;
    logic                      conv_start;
    logic [DATA_W-1:0]         conv_bin;
    logic                      conv_done;
    logic [BCD_W-1:0]          conv_bcd;
    logic                      busy;

    int n_checks = 0;
    int n_fail   = 0;

    // converter model: mdl_lat = 0 means it never completes
    int                mdl_lat = 30;
    int                mdl_cnt;
    logic              mdl_active;
    logic              mdl_done;
    logic [BCD_W-1:0]  mdl_bcd;
    logic [DATA_W-1:0] mdl_bin;
    logic              man_done = 1'b0;
    logic [BCD_W-1:0]  man_bcd = '0;

    assign conv_done = mdl_done | man_done;
    assign conv_bcd  = man_done ? man_bcd : mdl_bcd;

    always #10 sys_clk = ~sys_clk;

    bcd_conv_arbiter #(
        .NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .BCD_W(BCD_W), .TIMEOUT(63)
    ) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_bcd(rsp_bcd), .rsp_err(rsp_err),
        .conv_start(conv_start), .conv_bin(conv_bin),
        .conv_done(conv_done), .conv_bcd(conv_bcd), .busy(busy)
    );

    function automatic logic [15:0] bin2bcd(input int v);
        return {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    // Converter model: done arrives mdl_lat cycles after the start cycle.
    always @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            mdl_done   <= 1'b0;
            mdl_active <= 1'b0;
            mdl_cnt    <= 0;
            mdl_bcd    <= '0;
            mdl_bin    <= '0;
        end else begin
            mdl_done <= 1'b0;
            if (conv_start && mdl_lat > 0) begin
                mdl_active <= 1'b1;
                mdl_cnt    <= 1;
                mdl_bin    <= conv_bin;
            end else if (mdl_active) begin
                if (mdl_cnt == mdl_lat - 1) begin
                    mdl_done   <= 1'b1;
                    mdl_bcd    <= bin2bcd(int'(mdl_bin));
                    mdl_active <= 1'b0;
                end else begin
                    mdl_cnt <= mdl_cnt + 1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic apply_reset();
        sys_rst_n = 1'b0;
        req_valid = '0;
        man_done  = 1'b0;
        repeat (2) @(posedge sys_clk);
        #1;
        sys_rst_n = 1'b1;
        #1;
    endtask

    task automatic set_data(input int ch, input int val);
        req_data[ch*DATA_W +: DATA_W] = DATA_W'(val);
    endtask

    task automatic wait_ready(output logic [NUM_REQ-1:0] rdy, output bit ok);
        for (int c = 0; c < 200; c++) begin
            if (req_ready != '0) break;
            tick();
        end
        rdy = req_ready;
        ok  = (req_ready != '0);
    endtask

    // cyc counts cycles since the handshake cycle; c0 is the current offset
    task automatic wait_rsp(input int c0, output logic [NUM_REQ-1:0] v, output int cyc, output bit ok);
        cyc = c0;
        for (int c = 0; c < 200; c++) begin
            if (rsp_valid != '0) break;
            tick();
            cyc++;
        end
        v  = rsp_valid;
        ok = (rsp_valid != '0);
    endtask

    task automatic test_reset();
        sys_rst_n = 1'b0;
        req_valid = 4'b1111;
        #1;
        n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_req_ready: got %b expected 0000", req_ready); end
        n_checks++; if (rsp_valid !== 4'b0000) begin n_fail++; $display("FAIL reset_rsp_valid: got %b expected 0000", rsp_valid); end
        n_checks++; if (rsp_bcd !== 16'h0000) begin n_fail++; $display("FAIL reset_rsp_bcd: got %h expected 0000", rsp_bcd); end
        n_checks++; if (rsp_err !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_err: got %b expected 0", rsp_err); end
        n_checks++; if (conv_start !== 1'b0) begin n_fail++; $display("FAIL reset_conv_start: got %b expected 0", conv_start); end
        n_checks++; if (conv_bin !== 13'd0) begin n_fail++; $display("FAIL reset_conv_bin: got %0d expected 0", conv_bin); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    endtask

    task automatic test_single();
        logic [NUM_REQ-1:0] v;
        int cyc;
        bit ok;
        apply_reset();
        mdl_lat  = 30;
        req_data = '0;
        set_data(2, 1234);
        req_valid = 4'b0100;
        #1;
        n_checks++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL single_ready: got %b expected 0100", req_ready); end
        tick();
        req_valid = '0;
        #1;
        n_checks++; if (conv_start !== 1'b1) begin n_fail++; $display("FAIL single_start: got %b expected 1", conv_start); end
        n_checks++; if (conv_bin !== 13'd1234) begin n_fail++; $display("FAIL single_conv_bin: got %0d expected 1234", conv_bin); end
        n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL single_ready_drop: got %b expected 0000", req_ready); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy: got %b expected 1", busy); end
        tick();
        n_checks++; if (conv_start !== 1'b0) begin n_fail++; $display("FAIL single_start_pulse: got %b expected 0", conv_start); end
        wait_rsp(2, v, cyc, ok);
        n_checks++; if (!ok || cyc != 32) begin n_fail++; $display("FAIL single_latency: got %0d cycles expected 32", cyc); end
        n_checks++; if (v !== 4'b0100) begin n_fail++; $display("FAIL single_rsp_valid: got %b expected 0100", v); end
        n_checks++; if (rsp_bcd !== 16'h1234 || rsp_err !== 1'b0) begin n_fail++; $display("FAIL single_rsp: got %h/%b expected 1234/0", rsp_bcd, rsp_err); end
        tick();
        n_checks++; if (rsp_valid !== 4'b0000 || busy !== 1'b0) begin n_fail++; $display("FAIL single_rsp_end: got %b/%b expected 0000/0", rsp_valid, busy); end
        n_checks++; if (rsp_bcd !== 16'h1234) begin n_fail++; $display("FAIL single_bcd_hold: got %h expected 1234", rsp_bcd); end
    endtask

    task automatic test_all_four();
        int ops [4] = '{0, 9, 4095, 8191};
        logic [15:0] exp_bcd [4] = '{16'h0000, 16'h0009, 16'h4095, 16'h8191};
        logic [NUM_REQ-1:0] rdy, v, exp_oh;
        int cyc;
        bit ok;
        apply_reset();
        mdl_lat = 30;
        for (int i = 0; i < 4; i++) set_data(i, ops[i]);
        req_valid = 4'b1111;
        #1;
        for (int i = 0; i < 4; i++) begin
            exp_oh = 4'b0001 << i;
            wait_ready(rdy, ok);
            n_checks++; if (!ok || rdy !== exp_oh) begin n_fail++; $display("FAIL all4_grant%0d: got %b expected %b", i, rdy, exp_oh); end
            tick();
            req_valid[i] = 1'b0;
            wait_rsp(1, v, cyc, ok);
            n_checks++; if (!ok || v !== exp_oh) begin n_fail++; $display("FAIL all4_rsp%0d: got %b expected %b", i, v, exp_oh); end
            n_checks++; if (rsp_bcd !== exp_bcd[i] || rsp_err !== 1'b0) begin n_fail++; $display("FAIL all4_bcd%0d: got %h/%b expected %h/0", i, rsp_bcd, rsp_err, exp_bcd[i]); end
        end
        req_valid = 4'b0101;
        wait_ready(rdy, ok);
        n_checks++; if (!ok || rdy !== 4'b0001) begin n_fail++; $display("FAIL all4_wrap: got %b expected 0001", rdy); end
        tick();
        req_valid = '0;
    endtask

    task automatic test_fairness();
        int order [6] = '{1, 3, 1, 3, 1, 3};
        logic [NUM_REQ-1:0] rdy, v, exp_oh;
        logic [15:0] exp_bcd;
        int cyc;
        bit ok;
        apply_reset();
        mdl_lat = 30;
        set_data(1, 5);
        set_data(3, 77);
        req_valid = 4'b1010;
        #1;
        for (int i = 0; i < 6; i++) begin
            exp_oh  = 4'b0001 << order[i];
            exp_bcd = (order[i] == 1) ? 16'h0005 : 16'h0077;
            wait_ready(rdy, ok);
            n_checks++; if (!ok || rdy !== exp_oh) begin n_fail++; $display("FAIL fair_grant%0d: got %b expected %b", i, rdy, exp_oh); end
            tick();
            wait_rsp(1, v, cyc, ok);
            n_checks++; if (!ok || v !== exp_oh || rsp_bcd !== exp_bcd) begin n_fail++; $display("FAIL fair_rsp%0d: got %b/%h expected %b/%h", i, v, rsp_bcd, exp_oh, exp_bcd); end
        end
        req_valid = '0;
    endtask

    task automatic test_timeout();
        logic [NUM_REQ-1:0] rdy, v;
        int cyc;
        bit ok;
        apply_reset();
        mdl_lat = 0;
        set_data(0, 100);
        req_valid = 4'b0001;
        wait_ready(rdy, ok);
        n_checks++; if (!ok || rdy !== 4'b0001) begin n_fail++; $display("FAIL to_grant: got %b expected 0001", rdy); end
        tick();
        req_valid = '0;
        wait_rsp(1, v, cyc, ok);
        n_checks++; if (!ok || cyc != 65) begin n_fail++; $display("FAIL to_latency: got %0d cycles expected 65", cyc); end
        n_checks++; if (v !== 4'b0001 || rsp_err !== 1'b1 || rsp_bcd !== 16'h0000) begin n_fail++; $display("FAIL to_rsp: got %b/%b/%h expected 0001/1/0000", v, rsp_err, rsp_bcd); end
        tick();
        man_bcd  = 16'h5555;
        man_done = 1'b1;
        tick();
        man_done = 1'b0;
        n_checks++; if (rsp_valid !== 4'b0000 || busy !== 1'b0) begin n_fail++; $display("FAIL to_late_done: got %b/%b expected 0000/0", rsp_valid, busy); end
        n_checks++; if (rsp_bcd !== 16'h0000 || rsp_err !== 1'b1) begin n_fail++; $display("FAIL to_hold: got %h/%b expected 0000/1", rsp_bcd, rsp_err); end
        set_data(1, 7);
        req_valid = 4'b0010;
        #1;
        n_checks++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL to_idle_ready: got %b expected 0010", req_ready); end
        req_valid = '0;
    endtask

    task automatic test_done_at_timeout();
        logic [NUM_REQ-1:0] rdy, v;
        int cyc;
        bit ok;
        apply_reset();
        mdl_lat = 63;
        set_data(1, 8190);
        req_valid = 4'b0010;
        wait_ready(rdy, ok);
        n_checks++; if (!ok || rdy !== 4'b0010) begin n_fail++; $display("FAIL tie_grant: got %b expected 0010", rdy); end
        tick();
        req_valid = '0;
        wait_rsp(1, v, cyc, ok);
        n_checks++; if (!ok || cyc != 65 || v !== 4'b0010) begin n_fail++; $display("FAIL tie_rsp: got %b at %0d expected 0010 at 65", v, cyc); end
        n_checks++; if (rsp_err !== 1'b0 || rsp_bcd !== 16'h8190) begin n_fail++; $display("FAIL tie_result: got %b/%h expected 0/8190", rsp_err, rsp_bcd); end
    endtask

    task automatic test_reset_mid();
        logic [NUM_REQ-1:0] rdy, v;
        int cyc;
        bit ok;
        apply_reset();
        mdl_lat = 30;
        set_data(0, 42);
        req_valid = 4'b0001;
        wait_ready(rdy, ok);
        tick();
        req_valid = '0;
        repeat (5) tick();
        n_checks++; if (busy !== 1'b1 || conv_bin !== 13'd42) begin n_fail++; $display("FAIL rmid_pre: got %b/%0d expected 1/42", busy, conv_bin); end
        set_data(3, 321);
        req_valid = 4'b1000;
        #3;
        sys_rst_n = 1'b0;
        #1;
        n_checks++; if ({req_ready, rsp_valid, rsp_err, conv_start, busy} !== 11'd0) begin n_fail++; $display("FAIL rmid_ctrl: got %b/%b/%b/%b/%b expected all 0", req_ready, rsp_valid, rsp_err, conv_start, busy); end
        n_checks++; if (rsp_bcd !== 16'h0000 || conv_bin !== 13'd0) begin n_fail++; $display("FAIL rmid_data: got %h/%0d expected 0000/0", rsp_bcd, conv_bin); end
        tick();
        n_checks++; if (rsp_valid !== 4'b0000) begin n_fail++; $display("FAIL rmid_no_rsp: got %b expected 0000", rsp_valid); end
        sys_rst_n = 1'b1;
        #1;
        n_checks++; if (req_ready !== 4'b1000) begin n_fail++; $display("FAIL rmid_ch3_ready: got %b expected 1000", req_ready); end
        tick();
        req_valid = '0;
        wait_rsp(1, v, cyc, ok);
        n_checks++; if (!ok || cyc != 32 || v !== 4'b1000 || rsp_bcd !== 16'h0321) begin n_fail++; $display("FAIL rmid_ch3_rsp: got %b/%h at %0d expected 1000/0321 at 32", v, rsp_bcd, cyc); end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single();
        test_all_four();
        test_fairness();
        test_timeout();
        test_done_at_timeout();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bcd_conv_arbiter.md
Name: bcd_conv_arbiter

Overview:
- Shares one sequential binary-to-8421-BCD converter among NUM_REQ requesters, for example several averaged ADC channels feeding displays.
- Selects a requester by round-robin, launches one conversion, waits for completion or timeout, then returns the BCD result to that requester only.
- Sits between the measurement/averaging blocks and the converter; it is the only block that drives the converter's start input.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_W, 13, binary operand width
BCD_W, 16, BCD result width (4 digits)
TIMEOUT, 63, max cycles in WAIT before abort (1..255)

Ports:
sys_clk  in  1  system clock, 50 MHz
sys_rst_n  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  per-requester request; held until accepted
req_data  in  NUM_REQ*DATA_W  operands; requester i owns bits [i*DATA_W +: DATA_W]
req_ready  out  NUM_REQ  one-hot accept strobe
rsp_valid  out  NUM_REQ  one-hot 1-cycle result strobe
rsp_bcd  out  BCD_W  result, held until next response
rsp_err  out  1  qualifies rsp_valid; 1 = timeout abort
conv_start  out  1  1-cycle converter launch pulse
conv_bin  out  DATA_W  converter operand, held stable through WAIT
conv_done  in  1  converter 1-cycle completion pulse
conv_bcd  in  BCD_W  converter result, valid with conv_done
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (async, any state): state=IDLE, rr_ptr=0, grant index=0, timeout counter=0. All outputs are 0: req_ready, rsp_valid, rsp_bcd, rsp_err, conv_start, conv_bin, busy.
- FSM states: IDLE, START, WAIT, RESP.
- IDLE:
  - Compute the winner combinationally: the first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, … modulo NUM_REQ.
  - req_ready is one-hot for the winner and is asserted only in IDLE with req_valid high. It is 0 when no request is pending.
  - On handshake: latch grant index g and req_data slice into conv_bin, set rr_ptr=(g+1) mod NUM_REQ, go to START.
- START: conv_start=1 for exactly this cycle, clear the timeout counter, go to WAIT.
- WAIT:
  - Counter increments each cycle.
  - conv_done=1: capture conv_bcd into rsp_bcd, rsp_err=0, go to RESP.
  - Else if counter==TIMEOUT: rsp_bcd=0, rsp_err=1, go to RESP.
  - conv_done and the timeout in the same cycle: conv_done wins, so rsp_err=0.
- RESP: rsp_valid[g]=1 for exactly this cycle, go to IDLE. rsp_bcd and rsp_err hold until the next RESP.
- Latency:
  - Handshake in cycle T, conv_start in T+1.
  - If conv_done arrives in T+1+k (k≥1), rsp_valid is in T+2+k.
  - The earliest next req_ready is T+3+k.
- Fairness: with all requesters continuously valid, grants cycle 0,1,…,NUM_REQ-1,0.
- conv_done is ignored outside WAIT, including a late done after a timeout. Only one conversion is ever in flight.
- No internal queue. A deasserted req_valid before acceptance drops the request silently.
- Reset mid-conversion aborts with no rsp_valid. The converter is reset by the same sys_rst_n.

Test Plan:
- Converter model with a 30-cycle fixed latency. Drive req_valid=4'b0100, req_data[2]=1234 → req_ready=4'b0100 for 1 cycle, conv_start next cycle with conv_bin=1234, rsp_valid=4'b0100 with rsp_bcd=16'h1234 and rsp_err=0, 32 cycles after the handshake.
- Drive all four requests with operands 0, 9, 4095, 8191, held valid until accepted → responses in order ch0..ch3 with rsp_bcd 16'h0000, 16'h0009, 16'h4095, 16'h8191. A fifth request from ch0 is granted afterwards (pointer wrapped).
- Keep ch1 and ch3 continuously valid for 6 grants → grant order 1,3,1,3,1,3. No starvation.
- Converter model never asserts done → rsp_valid after 63 WAIT cycles with rsp_err=1 and rsp_bcd=0. A subsequent late conv_done is ignored and the FSM returns to IDLE.
- Assert conv_done in the same cycle the counter hits TIMEOUT → rsp_err=0 and rsp_bcd equals conv_bcd.
- Pulse sys_rst_n low during WAIT → all outputs 0 immediately with no rsp_valid. After release, a pending ch3 request is accepted (rr_ptr back to 0, search reaches 3).
